// File: rtl/mcif_write_eg_pkg.sv
// Shared definitions for the MCIF write-egress ack tracker.
// Command payload layout is {require_ack, cid}.
package mcif_write_eg_pkg;

    // The cid field is at least one bit wide, even when there is only one client.
    function automatic int cid_width(input int num_clients);
        return (num_clients <= 1) ? 1 : $clog2(num_clients);
    endfunction

    // The require_ack flag sits directly above the cid field.
    function automatic int ack_bit(input int num_clients);
        return cid_width(num_clients);
    endfunction

    localparam int CID_LSB = 0;

endpackage

// File: rtl/mcif_write_eg_ack_tracker_if.sv
// Bus bundle for the ack tracker: IG command events, AXI B channel,
// per-client completion pulses, full flags and the protocol-error flag.
// valid/ready: a transfer happens on a rising clock edge where valid and ready
// are both 1; valid and payload stay stable while valid=1 and ready=0.
interface mcif_write_eg_ack_tracker_if #(
    parameter int NUM_CLIENTS = 5,
    parameter int ID_W        = 8
) ();
    import mcif_write_eg_pkg::*;

    localparam int CID_W = cid_width(NUM_CLIENTS);

    logic                   ig2eg_cmd_valid;
    logic                   ig2eg_cmd_ready;
    logic [CID_W:0]         ig2eg_cmd_pd;
    logic                   noc2mcif_axi_b_bvalid;
    logic                   mcif2noc_axi_b_bready;
    logic [ID_W-1:0]        noc2mcif_axi_b_bid;
    logic [NUM_CLIENTS-1:0] mcif2client_wr_rsp_complete;
    logic [NUM_CLIENTS-1:0] eg2ig_os_full;
    logic                   eg_err_unexpected_b;

    // Driver side: IG arbiter, NOC and clients.
    modport master (
        output ig2eg_cmd_valid, ig2eg_cmd_pd, noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid,
        input  ig2eg_cmd_ready, mcif2noc_axi_b_bready, mcif2client_wr_rsp_complete,
               eg2ig_os_full, eg_err_unexpected_b
    );

    // Tracker side.
    modport slave (
        input  ig2eg_cmd_valid, ig2eg_cmd_pd, noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid,
        output ig2eg_cmd_ready, mcif2noc_axi_b_bready, mcif2client_wr_rsp_complete,
               eg2ig_os_full, eg_err_unexpected_b
    );

endinterface

// File: rtl/mcif_write_eg_ackq.sv
// One-bit-wide flop FIFO holding require_ack flags of outstanding writes
// for a single client. Push and pop in the same cycle are legal; the caller
// never pushes when full nor pops when empty.
module mcif_write_eg_ackq #(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             push,
    input  logic             push_data,
    input  logic             pop,
    output logic             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage, pointers (wrap naturally since DEPTH is a power of 2) and count.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
        end
    end

    // The head is read before this cycle's write lands, so a same-cycle
    // push never shows up as the popped entry.
    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mcif_write_eg_ack_tracker.sv
// Write-egress ack tracker: one ack queue per client, filled by IG command
// events and retired in order by AXI B responses. Retiring an entry whose
// require_ack=1 produces a one-cycle completion pulse for that client.
// Optional checker: define MCIF_WRITE_EG_BID_CHECK_EN to flag B responses
// that hit an empty queue or an out-of-range client (sticky until reset).
module mcif_write_eg_ack_tracker #(
    parameter int NUM_CLIENTS = 5,
    parameter int OS_DEPTH    = 8,
    parameter int ID_W        = 8
) (
    input logic                   nvdla_core_clk,
    input logic                   nvdla_core_rstn,
    mcif_write_eg_ack_tracker_if.slave bus
);
    import mcif_write_eg_pkg::*;

    localparam int CID_W   = cid_width(NUM_CLIENTS);
    localparam int ACK_BIT = ack_bit(NUM_CLIENTS);
    localparam int CNT_W   = $clog2(OS_DEPTH + 1);

    logic [CID_W-1:0]                  cmd_cid;
    logic                              cmd_ack;
    logic [CID_W-1:0]                  b_cid;
    logic [NUM_CLIENTS-1:0]            cmd_sel;
    logic [NUM_CLIENTS-1:0]            b_sel;
    logic [NUM_CLIENTS-1:0]            q_push;
    logic [NUM_CLIENTS-1:0]            q_pop;
    logic [NUM_CLIENTS-1:0]            q_head;
    logic [NUM_CLIENTS-1:0]            q_full;
    logic [NUM_CLIENTS-1:0]            q_empty;
    logic [NUM_CLIENTS-1:0][CNT_W-1:0] q_count;
    logic [NUM_CLIENTS-1:0]            complete;
    logic                              unused_count;

    assign cmd_cid = bus.ig2eg_cmd_pd[CID_LSB +: CID_W];
    assign cmd_ack = bus.ig2eg_cmd_pd[ACK_BIT];
    assign b_cid   = bus.noc2mcif_axi_b_bid[CID_W-1:0];

    genvar c;
    generate
        for (c = 0; c < NUM_CLIENTS; c++) begin : g_q
            // An out-of-range cid matches no client, so it is never accepted.
            assign cmd_sel[c] = (cmd_cid == CID_W'(c));
            assign b_sel[c]   = (b_cid == CID_W'(c));

            mcif_write_eg_ackq #(.DEPTH(OS_DEPTH)) u_q (
                .nvdla_core_clk  (nvdla_core_clk),
                .nvdla_core_rstn (nvdla_core_rstn),
                .push            (q_push[c]),
                .push_data       (cmd_ack),
                .pop             (q_pop[c]),
                .head            (q_head[c]),
                .count           (q_count[c]),
                .full            (q_full[c]),
                .empty           (q_empty[c])
            );
        end
        if (ID_W > CID_W) begin : g_bid_hi
            logic unused_bid_hi;
            assign unused_bid_hi = ^bus.noc2mcif_axi_b_bid[ID_W-1:CID_W];
        end
    endgenerate

    assign unused_count = ^q_count;

    // Full is already a registered view (derived from the count flops), so a
    // full client refuses even when it is being popped this cycle.
    assign bus.ig2eg_cmd_ready       = |(cmd_sel & ~q_full);
    assign q_push                    = {NUM_CLIENTS{bus.ig2eg_cmd_valid}} & cmd_sel & ~q_full;
    assign q_pop                     = {NUM_CLIENTS{bus.noc2mcif_axi_b_bvalid}} & b_sel & ~q_empty;
    assign bus.mcif2noc_axi_b_bready = 1'b1;
    assign bus.eg2ig_os_full         = q_full;
    assign bus.mcif2client_wr_rsp_complete = complete;

    // Completion pulse one cycle after the B that retires an ack-requesting entry.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            complete <= '0;
        end else begin
            complete <= q_pop & q_head;
        end
    end

`ifdef MCIF_WRITE_EG_BID_CHECK_EN
    logic err;

    // Sticky flag for a B that retired nothing (empty queue or bad client).
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            err <= 1'b0;
        end else if (bus.noc2mcif_axi_b_bvalid && (q_pop == '0)) begin
            err <= 1'b1;
        end
    end

    assign bus.eg_err_unexpected_b = err;
`else
    assign bus.eg_err_unexpected_b = 1'b0;
`endif

    // IG must only issue commands for existing clients.
    a_cid_in_range: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        bus.ig2eg_cmd_valid |-> (cmd_sel != '0));

endmodule

// File: tb/tb_mcif_write_eg_ack_tracker.sv
// Directed bench for the write-egress ack tracker. Inputs change and outputs
// are sampled on the falling clock edge; the design acts on the rising edge.
module tb_mcif_write_eg_ack_tracker;

    logic clk;
    logic rstn;
    int   checks;
    int   passed;
    int   failed;
    logic exp_err;

    mcif_write_eg_ack_tracker_if #(.NUM_CLIENTS(5), .ID_W(8)) bus ();

    mcif_write_eg_ack_tracker #(.NUM_CLIENTS(5), .OS_DEPTH(8), .ID_W(8)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus.slave)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic valid, input logic ack, input logic [2:0] cid);
        bus.ig2eg_cmd_valid = valid;
        bus.ig2eg_cmd_pd    = {ack, cid};
    endtask

    task automatic b(input logic valid, input logic [7:0] id);
        bus.noc2mcif_axi_b_bvalid = valid;
        bus.noc2mcif_axi_b_bid    = id;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        failed = 0;
`ifdef MCIF_WRITE_EG_BID_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rstn = 1'b0;
        cmd(1'b0, 1'b0, 3'd0);
        b(1'b0, 8'h00);
        repeat (2) @(negedge clk);

        // 1. Reset state.
        chk("rst_ready", 32'(bus.ig2eg_cmd_ready), 32'd1);
        chk("rst_bready", 32'(bus.mcif2noc_axi_b_bready), 32'd1);
        chk("rst_complete", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);
        chk("rst_os_full", 32'(bus.eg2ig_os_full), 32'd0);
        chk("rst_err", 32'(bus.eg_err_unexpected_b), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // 2. Ack-requesting write on client 2, pulse 1 clk after B.
        cmd(1'b1, 1'b1, 3'd2);
        #1 chk("s2_ready", 32'(bus.ig2eg_cmd_ready), 32'd1);
        @(negedge clk);
        cmd(1'b0, 1'b0, 3'd0);
        b(1'b1, 8'h02);
        chk("s2_count_after_push", 32'(dut.q_count[2]), 32'd1);
        chk("s2_no_early_pulse", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);
        @(negedge clk);
        b(1'b0, 8'h00);
        chk("s2_pulse", 32'(bus.mcif2client_wr_rsp_complete), 32'b00100);
        chk("s2_count_after_pop", 32'(dut.q_count[2]), 32'd0);
        @(negedge clk);
        chk("s2_pulse_one_cycle", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);

        // 3. No-ack write on client 1 retires silently.
        cmd(1'b1, 1'b0, 3'd1);
        @(negedge clk);
        cmd(1'b0, 1'b0, 3'd0);
        b(1'b1, 8'h01);
        @(negedge clk);
        b(1'b0, 8'h00);
        chk("s3_no_pulse", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);
        chk("s3_count", 32'(dut.q_count[1]), 32'd0);

        // 4. Fill client 0, then refused push alongside a pop.
        for (int i = 0; i < 8; i++) begin
            cmd(1'b1, 1'b0, 3'd0);
            @(negedge clk);
        end
        chk("s4_full", 32'(bus.eg2ig_os_full), 32'b00001);
        chk("s4_ready_full", 32'(bus.ig2eg_cmd_ready), 32'd0);
        chk("s4_count_full", 32'(dut.q_count[0]), 32'd8);
        b(1'b1, 8'h00);
        @(negedge clk);
        cmd(1'b0, 1'b0, 3'd0);
        b(1'b0, 8'h00);
        chk("s4_push_refused", 32'(dut.q_count[0]), 32'd7);
        chk("s4_full_drop", 32'(bus.eg2ig_os_full), 32'd0);
        chk("s4_no_pulse", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);
        for (int i = 0; i < 7; i++) begin
            b(1'b1, 8'h00);
            @(negedge clk);
        end
        b(1'b0, 8'h00);
        chk("s4_drained", 32'(dut.q_count[0]), 32'd0);

        // 5. Same-cycle push+pop on client 3 pops the old (no-ack) head.
        cmd(1'b1, 1'b0, 3'd3);
        @(negedge clk);
        cmd(1'b1, 1'b1, 3'd3);
        b(1'b1, 8'h03);
        @(negedge clk);
        cmd(1'b0, 1'b0, 3'd0);
        b(1'b0, 8'h00);
        chk("s5_count_kept", 32'(dut.q_count[3]), 32'd1);
        chk("s5_old_head_no_pulse", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);
        b(1'b1, 8'h03);
        @(negedge clk);
        b(1'b0, 8'h00);
        chk("s5_new_entry_pulse", 32'(bus.mcif2client_wr_rsp_complete), 32'b01000);
        chk("s5_count_empty", 32'(dut.q_count[3]), 32'd0);

        // Back-to-back B on client 4 pulses every cycle.
        for (int i = 0; i < 3; i++) begin
            cmd(1'b1, 1'b1, 3'd4);
            @(negedge clk);
        end
        cmd(1'b0, 1'b0, 3'd0);
        b(1'b1, 8'h04);
        @(negedge clk);
        chk("b2b_pulse_1", 32'(bus.mcif2client_wr_rsp_complete), 32'b10000);
        @(negedge clk);
        chk("b2b_pulse_2", 32'(bus.mcif2client_wr_rsp_complete), 32'b10000);
        @(negedge clk);
        b(1'b0, 8'h00);
        chk("b2b_pulse_3", 32'(bus.mcif2client_wr_rsp_complete), 32'b10000);
        @(negedge clk);
        chk("b2b_pulse_end", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);
        chk("b2b_count", 32'(dut.q_count[4]), 32'd0);

        // Independent push on client 1 and pop on client 2; bid upper bits ignored.
        cmd(1'b1, 1'b1, 3'd2);
        @(negedge clk);
        cmd(1'b1, 1'b1, 3'd1);
        b(1'b1, 8'hA2);
        @(negedge clk);
        cmd(1'b0, 1'b0, 3'd0);
        b(1'b0, 8'h00);
        chk("mix_pulse_c2", 32'(bus.mcif2client_wr_rsp_complete), 32'b00100);
        chk("mix_count_c1", 32'(dut.q_count[1]), 32'd1);
        chk("mix_count_c2", 32'(dut.q_count[2]), 32'd0);
        b(1'b1, 8'h01);
        @(negedge clk);
        b(1'b0, 8'h00);
        chk("mix_pulse_c1", 32'(bus.mcif2client_wr_rsp_complete), 32'b00010);
        chk("err_clean_traffic", 32'(bus.eg_err_unexpected_b), 32'd0);

        // 6. Unexpected B: empty queue, then out-of-range client.
        b(1'b1, 8'h04);
        @(negedge clk);
        b(1'b0, 8'h00);
        chk("s6_no_pulse", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);
        chk("s6_err", 32'(bus.eg_err_unexpected_b), 32'(exp_err));
        chk("s6_count_c4", 32'(dut.q_count[4]), 32'd0);
        b(1'b1, 8'h07);
        @(negedge clk);
        b(1'b0, 8'h00);
        @(negedge clk);
        chk("s6_bad_cid_no_pulse", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);
        chk("s6_err_held", 32'(bus.eg_err_unexpected_b), 32'(exp_err));

        // Reset mid-operation discards pending entries.
        cmd(1'b1, 1'b1, 3'd2);
        @(negedge clk);
        cmd(1'b0, 1'b0, 3'd0);
        chk("rst2_pending", 32'(dut.q_count[2]), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst2_count", 32'(dut.q_count[2]), 32'd0);
        chk("rst2_err", 32'(bus.eg_err_unexpected_b), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        b(1'b1, 8'h02);
        @(negedge clk);
        b(1'b0, 8'h00);
        chk("rst2_no_lost_pulse", 32'(bus.mcif2client_wr_rsp_complete), 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
